// File: rtl/display_mux_ctrl_pkg.sv
// display_pkg: shared types and constants for the seven-segment mux scheduler.
//   mux_state_t : scheduler state (BLANK gap / DRIVE one digit)
//   SEG_BLANK   : all segments off (active-low)
//   SEG_LUT     : hex nibble -> {g,f,e,d,c,b,a}, active-low
//   seg_decode  : table lookup helper
package display_pkg;

  typedef enum logic {BLANK, DRIVE} mux_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index 15 sits in the top slice, index 0 in the bottom slice.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/display_mux_ctrl_if.sv
// display_mux_ctrl_if: digit data/mask from the adder side and the
// multiplexed pin-side outputs.
//   digit_data : NDIG hex nibbles, digit i in slice [i]
//   digit_en   : per-digit rotation mask
//   en         : one-hot digit common enable (active-high)
//   seg_n      : segment lines {g..a}, active-low
//   cur_digit  : digit being or last driven
// master = nibble/mask source, slave = scheduler.
interface display_mux_ctrl_if #(
  parameter int NDIG = 2
);
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [NDIG-1:0][3:0] digit_data;
  logic [NDIG-1:0]      digit_en;
  logic [NDIG-1:0]      en;
  logic [6:0]           seg_n;
  logic [CW-1:0]        cur_digit;

  modport master (output digit_data, digit_en, input en, seg_n, cur_digit);
  modport slave  (input digit_data, digit_en, output en, seg_n, cur_digit);
endinterface

// File: rtl/display_mux_ctrl_seg_decoder.sv
// seg_decoder: combinational hex nibble to active-low seven-segment pattern.
//   nib   : 4-bit hex value
//   seg_n : {g,f,e,d,c,b,a}, active-low
module seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);
  assign seg_n = seg_decode(nib);
endmodule

// File: rtl/display_mux_ctrl.sv
// display_mux_ctrl: round-robin scheduler for a shared seven-segment bus.
// Drives one enabled digit for DWELL_CYCLES, then blanks for BLANK_CYCLES
// before moving to the next enabled digit; disabled digits are skipped.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : slave side of display_mux_ctrl_if (data/mask in, en/seg_n/cur_digit out)
module display_mux_ctrl
  import display_pkg::*;
#(
  parameter int NDIG         = 2,
  parameter int DWELL_CYCLES = 24000,
  parameter int BLANK_CYCLES = 480
) (
  input logic               clk,
  input logic               reset,
  display_mux_ctrl_if.slave bus
);
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CNTW-1:0] BLANK_LAST = CNTW'(BLANK_CYCLES - 1);
  localparam logic [CNTW-1:0] DWELL_LAST = CNTW'(DWELL_CYCLES - 1);

  mux_state_t      state;
  logic [CNTW-1:0] cnt;
  logic [NDIG-1:0] en_reg;
  logic [6:0]      seg_reg;
  logic [CW-1:0]   cur_reg;

  logic            found;
  logic [CW-1:0]   nxt;
  logic [6:0]      nxt_seg;

  function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base, input int k);
    return CW'((int'(base) + k) % NDIG);
  endfunction

  // Rotation search from cur+1 round to cur itself. Walking k downwards
  // lets the nearest enabled digit win the last assignment.
  always_comb begin
    found = 1'b0;
    nxt   = cur_reg;
    for (int k = NDIG; k >= 1; k--) begin
      if (bus.digit_en[wrap_idx(cur_reg, k)]) begin
        found = 1'b1;
        nxt   = wrap_idx(cur_reg, k);
      end
    end
  end

  // Decode the nibble at the moment it is captured; seg_reg then acts as the
  // holding register, so later digit_data changes wait for the next visit.
  seg_decoder u_dec (
    .nib   (bus.digit_data[nxt]),
    .seg_n (nxt_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= BLANK;
      cnt     <= '0;
      en_reg  <= '0;
      seg_reg <= SEG_BLANK;
      cur_reg <= CW'(NDIG - 1);  // first search lands on digit 0
    end else begin
      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            // Saturated: keep searching every cycle until a digit is enabled.
            if (found) begin
              state   <= DRIVE;
              cnt     <= '0;
              cur_reg <= nxt;
              en_reg  <= NDIG'(1) << nxt;
              seg_reg <= nxt_seg;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRIVE: begin
          // A digit dropped from the mask is cut off mid-dwell.
          if (cnt == DWELL_LAST || !bus.digit_en[cur_reg]) begin
            state   <= BLANK;
            cnt     <= '0;
            en_reg  <= '0;
            seg_reg <= SEG_BLANK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= BLANK;
          cnt     <= '0;
          en_reg  <= '0;
          seg_reg <= SEG_BLANK;
        end
      endcase
    end
  end

  assign bus.en        = en_reg;
  assign bus.seg_n     = seg_reg;
  assign bus.cur_digit = cur_reg;

endmodule

// File: doc/display_mux_ctrl.md
# display_mux_ctrl

Time-multiplexing scheduler for the shared seven-segment bus. It cycles through NDIG hex digits and drives one digit's common enable at a time. It inserts a blanking interval before every digit change to suppress ghosting, and skips digits whose enable bit is clear. It sits between the switch/adder logic (which supplies the nibbles) and the board pins (seven segment lines plus per-digit enables).

## Interface
- NDIG, 2: number of multiplexed digits (1–8).
- DWELL_CYCLES, 24000: clock cycles a digit is driven per visit (0.5 ms at 48 MHz).
- BLANK_CYCLES, 480: clock cycles of all-off between visits (≥1).
- clk  in  1  system clock (internal oscillator).
- reset  in  1  synchronous, active-high reset.
- digit_data  in  4*NDIG  hex nibbles; digit i is bits [4i+3:4i].
- digit_en  in  NDIG  per-digit display mask; 1 = include in rotation.
- en  out  NDIG  one-hot digit enable, active-high; all-zero while blanking.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low; 7'h7F while blanking.
- cur_digit  out  $clog2(NDIG) (min 1)  index of the digit being or last driven.

## Operation
- Two states: BLANK and DRIVE. One cycle counter `cnt`, width sized for max(DWELL_CYCLES, BLANK_CYCLES).
- Reset values: state = BLANK, cnt = 0, en = 0, seg_n = 7'h7F, cur_digit = NDIG-1. Because cur_digit resets to NDIG-1, the first digit driven is digit 0.
- BLANK behaviour:
  - en = 0 and seg_n = 7'h7F.
  - cnt increments and saturates at BLANK_CYCLES-1.
- Leaving BLANK (when cnt == BLANK_CYCLES-1):
  - Search for the next enabled digit, starting at cur_digit+1 modulo NDIG and wrapping to include cur_digit itself.
  - If one is found: go to DRIVE, cnt = 0, cur_digit = the found index, and capture that digit's nibble into a holding register.
  - If none is enabled: stay in BLANK with cnt saturated, and re-run the search every cycle.
- DRIVE behaviour:
  - en = one-hot(cur_digit); seg_n = decode(held nibble).
  - Changes to digit_data during DRIVE have no effect until the next visit.
- Leaving DRIVE:
  - When cnt == DWELL_CYCLES-1, go to BLANK with cnt = 0.
  - If digit_en[cur_digit] falls during DRIVE, go to BLANK on the next edge with cnt = 0, even mid-dwell.
- Decode table, seg_n {g..a}, active-low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- en and seg_n are registered and change on the same edge. en is never non-zero on two consecutive digits without a blank between them.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- After reset is released, en first asserts BLANK_CYCLES cycles later, provided digit_en[0] = 1.
- Each visit: en held for exactly DWELL_CYCLES cycles, followed by exactly BLANK_CYCLES cycles of blank.
- Rotation period with k enabled digits is k*(DWELL_CYCLES+BLANK_CYCLES) cycles. With k = 1 the same digit repeats, still blanked between visits.
- digit_en going from all-zero to non-zero while saturated in BLANK: DRIVE starts on the next edge, i.e. en asserts 1 cycle later.
- Reset asserted mid-DRIVE: on the next edge en = 0, seg_n = 7'h7F, and the rotation restarts from digit 0.

## Structure
- Package display_pkg holds:
  - `typedef enum logic {BLANK, DRIVE} mux_state_t`
  - `SEG_BLANK = 7'h7F`
  - the 16-entry decode constant.
- Sub-module seg_decoder: combinational, 4-bit nibble to 7-bit active-low seg_n. Also reused by the top level. Its output is registered inside display_mux_ctrl.

## Test plan
All scenarios use NDIG = 2, DWELL_CYCLES = 8, BLANK_CYCLES = 2.
- Reset, then digit_en = 2'b11, digit_data = 8'h3A → en = 00 and seg_n = 7F for 2 cycles; then en = 01, seg_n = 0001000 (A) for 8 cycles; then 2 cycles blank; then en = 10, seg_n = 0110000 (3) for 8 cycles; period = 20.
- digit_en = 2'b01 → only en = 01 ever appears, 8 on / 2 off, period 10; cur_digit stays 0.
- digit_en = 2'b00 for 50 cycles → en = 00 and seg_n = 7F throughout. Then set digit_en = 2'b10 → en = 10 one cycle later.
- digit_data changes from 8'h3A to 8'h35 on cycle 3 of digit 0's dwell → seg_n holds A for the rest of that dwell; the next digit-0 visit shows 5 (0010010).
- Clear digit_en[0] on cycle 4 of digit 0's dwell → en = 00 on the next edge; 2-cycle blank follows; then en = 10.
- Assert reset for 1 cycle during digit 1's dwell → en = 00 and seg_n = 7F on the next edge; the next drive is digit 0, after 2 blank cycles.
